reg_transfer_sequencer: RTL and testbench

//  Upstream driver for the register bank of the relay machine: executes one MOV dst,src per request.

---
 rtl/relay_pkg.sv | 28 ++
 rtl/reg_transfer_sequencer_phase_timer.sv | 28 ++
 rtl/reg_transfer_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reg_transfer_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared definitions for the relay-machine register transfer path:
// transfer FSM states, register bank indices and default bus geometry.
package relay_pkg;

  localparam int DEF_NUM_REG = 8;
  localparam int DEF_WIDTH   = 8;
  localparam int STATE_W     = 3;

  // Register bank indices as wired on the data bus.
  localparam int REG_A  = 0;
  localparam int REG_B  = 1;
  localparam int REG_C  = 2;
  localparam int REG_D  = 3;
  localparam int REG_M1 = 4;
  localparam int REG_M2 = 5;
  localparam int REG_X  = 6;
  localparam int REG_Y  = 7;

  // Transfer FSM encoding, fixed values so debug dumps stay comparable.
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/reg_transfer_sequencer_phase_timer.sv
// Loadable down-counter that times each relay phase.
// A load takes priority; otherwise the count decrements and parks at zero.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Reload on request, else count down towards zero and hold there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Executes one MOV dst,src on the relay register bank: raises sel[src]
// to put the source on the wired-OR bus, lets it settle, pulses load[dst],
// releases load while the bus is still driven, then reports done.
//
// Handshake: start is sampled only in IDLE together with src_idx/dst_idx.
// A valid request makes busy high from the next cycle until the cycle after
// the done pulse; done is a single-cycle pulse with busy still high. Requests
// with an out-of-range index produce a one-cycle err pulse and nothing else.
// start seen while busy is ignored, so holding start high chains transfers
// with one IDLE cycle between them.
//
// DONE lasts two cycles: a quiet cycle with the bus released, then the cycle
// carrying the done pulse, so the bank sees an undriven bus before the
// sequencer reports completion.
module reg_transfer_sequencer
  import relay_pkg::*;
#(
  parameter int NUM_REG    = DEF_NUM_REG,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SEL_SETTLE = 2,
  parameter int LOAD_HOLD  = 2,
  parameter int IDX_W      = $clog2(NUM_REG)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IDX_W-1:0]           src_idx,
  input  logic [IDX_W-1:0]           dst_idx,
  input  logic [NUM_REG*WIDTH-1:0]   reg_q,
  output logic [NUM_REG-1:0]         sel,
  output logic [NUM_REG-1:0]         load,
  output logic [WIDTH-1:0]           bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [STATE_W-1:0]         o_dbg_state
);

  localparam int MAX_PH = (SEL_SETTLE > LOAD_HOLD) ? SEL_SETTLE : LOAD_HOLD;
  localparam int TW     = $clog2(MAX_PH + 1);

  generate
    if (SEL_SETTLE < 1) begin : g_bad_settle
      $fatal(1, "SEL_SETTLE must be at least 1");
    end
    if (LOAD_HOLD < 1) begin : g_bad_hold
      $fatal(1, "LOAD_HOLD must be at least 1");
    end
    if (NUM_REG < 2) begin : g_bad_nreg
      $fatal(1, "NUM_REG must be at least 2");
    end
  endgenerate

  xfer_state_t          r_state;
  xfer_state_t          w_next;
  logic [IDX_W-1:0]     r_src;
  logic [IDX_W-1:0]     r_dst;
  logic [NUM_REG-1:0]   r_sel;
  logic [NUM_REG-1:0]   r_load;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_idx_ok;
  logic                 w_start_bad;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_src;
  logic [IDX_W-1:0]     w_dst;
  logic [NUM_REG-1:0]   w_src_oh;
  logic [NUM_REG-1:0]   w_dst_oh;
  logic                 w_drive_sel;
  logic                 w_tmr_load;
  logic [TW-1:0]        w_tmr_val;
  logic                 w_tmr_zero;

  phase_timer #(.W(TW)) u_timer (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  assign w_idx_ok = (32'(src_idx) < 32'(NUM_REG)) && (32'(dst_idx) < 32'(NUM_REG));
  assign w_accept = (r_state == IDLE) && (w_next == SELECT);

  // Indices in effect for the next cycle: live inputs when a request is taken.
  assign w_src    = (r_state == IDLE) ? src_idx : r_src;
  assign w_dst    = (r_state == IDLE) ? dst_idx : r_dst;
  assign w_src_oh = NUM_REG'(1) << w_src;
  assign w_dst_oh = NUM_REG'(1) << w_dst;

  // src==dst is a clear: the bus stays undriven so the destination loads 0.
  assign w_drive_sel = (w_next inside {SELECT, LOAD, RELEASE}) && (w_src != w_dst);

  // Next state and phase timer reloads.
  always_comb begin
    w_next      = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_start_bad = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_idx_ok) begin
            w_next     = SELECT;
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(SEL_SETTLE - 1);
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      SELECT: begin
        if (w_tmr_zero) begin
          w_next     = LOAD;
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(LOAD_HOLD - 1);
        end
      end
      LOAD: begin
        if (w_tmr_zero) begin
          w_next = RELEASE;
        end
      end
      RELEASE: begin
        w_next     = DONE;
        w_tmr_load = 1'b1;
        w_tmr_val  = TW'(1);
      end
      DONE: begin
        if (w_tmr_zero) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register and latched operand indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= src_idx;
        r_dst <= dst_idx;
      end
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel  <= '0;
      r_load <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_sel  <= w_drive_sel ? w_src_oh : '0;
      r_load <= (w_next == LOAD) ? w_dst_oh : '0;
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == DONE) && !w_tmr_zero;
      r_err  <= w_start_bad;
    end
  end

  // Wired-OR bus: every selected register contributes its slice.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (r_sel[i]) begin
        bus = bus | reg_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel         = r_sel;
  assign load        = r_load;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench for reg_transfer_sequencer. Instance a uses the default
// phase timing with a widened index port; instance b uses the shortest
// timing (SEL_SETTLE=1, LOAD_HOLD=1).
module tb_reg_transfer_sequencer;
  import relay_pkg::*;

  localparam int SA = 2;
  localparam int LA = 2;
  localparam int SB = 1;
  localparam int LB = 1;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [3:0]  src_idx, dst_idx;
  logic [63:0] reg_q;
  logic [7:0]  sel_a, load_a, bus_a, sel_b, load_b, bus_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [2:0]  dbg_a, dbg_b;
  logic [31:0] got_a, got_b;

  assign reg_q = {8'h99, 8'h81, 8'h42, 8'h24, 8'h0F, 8'h7E, 8'h3C, 8'hA5};
  assign got_a = {5'b0, busy_a, done_a, err_a, load_a, sel_a, bus_a};
  assign got_b = {5'b0, busy_b, done_b, err_b, load_b, sel_b, bus_b};

  reg_transfer_sequencer #(
    .NUM_REG(8), .WIDTH(8), .SEL_SETTLE(SA), .LOAD_HOLD(LA), .IDX_W(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .src_idx(src_idx), .dst_idx(dst_idx), .reg_q(reg_q),
    .sel(sel_a), .load(load_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err(err_a), .o_dbg_state(dbg_a)
  );

  reg_transfer_sequencer #(
    .NUM_REG(8), .WIDTH(8), .SEL_SETTLE(SB), .LOAD_HOLD(LB)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .src_idx(src_idx[2:0]), .dst_idx(dst_idx[2:0]), .reg_q(reg_q),
    .sel(sel_b), .load(load_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err(err_b), .o_dbg_state(dbg_b)
  );

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  int cur_src_b = 0;
  int cur_dst_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected {busy,done,err,load,sel,bus} for cycle c after the first start edge.
  function automatic logic [31:0] exp_word(int c, int s, int l, int nx, int src, int dst);
    int p;
    int ph;
    logic [7:0] e_sel;
    logic [7:0] e_load;
    logic [7:0] e_bus;
    logic e_done;
    logic e_busy;
    p = s + l + 4;
    if (c > nx * p) return 32'd0;
    ph     = ((c - 1) % p) + 1;
    e_sel  = (ph <= s + l + 1 && src != dst) ? 8'(1 << src) : 8'h00;
    e_load = (ph >= s + 1 && ph <= s + l) ? 8'(1 << dst) : 8'h00;
    e_bus  = (e_sel != 0) ? reg_q[src*8 +: 8] : 8'h00;
    e_done = (ph == s + l + 3);
    e_busy = (ph <= s + l + 3);
    return {5'b0, e_busy, e_done, 1'b0, e_load, e_sel, e_bus};
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else start_b = v;
  endtask

  task automatic cmp_cycle(input int which, input int c, input logic [31:0] exp);
    logic [31:0] got;
    string pfx;
    got = (which == 0) ? got_a : got_b;
    pfx = $sformatf("%s c%0d", (which == 0) ? "a" : "b", c);
    check({pfx, " sel"},  {24'd0, got[15:8]},  {24'd0, exp[15:8]});
    check({pfx, " load"}, {24'd0, got[23:16]}, {24'd0, exp[23:16]});
    check({pfx, " bus"},  {24'd0, got[7:0]},   {24'd0, exp[7:0]});
    check({pfx, " stat"}, {29'd0, got[26:24]}, {29'd0, exp[26:24]});
  endtask

  // Driver: nx transfers with start held until the last one is taken.
  task automatic run_xfer(input int which, input int src, input int dst, input int nx);
    int s, l, p, drop_at;
    s = (which == 0) ? SA : SB;
    l = (which == 0) ? LA : LB;
    p = s + l + 4;
    drop_at = (nx - 1) * p;
    if (which == 1) begin
      cur_src_b = src;
      cur_dst_b = dst;
    end
    for (int c = 1; c <= nx * p + 1; c++) exp_q.push_back(exp_word(c, s, l, nx, src, dst));
    @(negedge clk);
    src_idx = 4'(src);
    dst_idx = 4'(dst);
    set_start(which, 1'b1);
    if (drop_at == 0) begin
      @(posedge clk);
      #1 set_start(which, 1'b0);
    end
    for (int c = 1; c <= nx * p + 1; c++) begin
      @(negedge clk);
      cmp_cycle(which, c, exp_q.pop_front());
      if (c == drop_at) begin
        @(posedge clk);
        #1 set_start(which, 1'b0);
      end
    end
  endtask

  // Continuous invariants: one-hot-or-zero strobes, load implies sel[src].
  always @(negedge clk) begin
    if (!reset) begin
      check("oh_a", 32'($onehot0(sel_a) && $onehot0(load_a)), 32'd1);
      check("oh_b", 32'($onehot0(sel_b) && $onehot0(load_b)), 32'd1);
      if (load_b != 8'h00 && cur_src_b != cur_dst_b)
        check("ld_sel_b", 32'(sel_b[cur_src_b]), 32'd1);
    end
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    src_idx = '0;
    dst_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_a", got_a, 32'd0);
    check("rst_b", got_b, 32'd0);
    check("rst_dbg_a", 32'(dbg_a), 32'd0);
    check("rst_dbg_b", 32'(dbg_b), 32'd0);
    reset = 1'b0;

    // MOV B,A: sel 5 cycles, load 2 cycles, bus A5, done in cycle 7.
    run_xfer(0, REG_A, REG_B, 1);
    // MOV C,C: clear, bus stays 0.
    run_xfer(0, REG_C, REG_C, 1);
    // MOV D,X twice with start held high.
    run_xfer(0, REG_X, REG_D, 2);

    // Out-of-range destination: err pulse only.
    @(negedge clk);
    src_idx = 4'd0;
    dst_idx = 4'd8;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    check("err_pulse", got_a, 32'h0100_0000);
    @(negedge clk);
    check("err_after", got_a, 32'd0);
    // Out-of-range source.
    src_idx = 4'd9;
    dst_idx = 4'd1;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    check("err_src", got_a, 32'h0100_0000);

    // Short timing instance: done in cycle 5.
    run_xfer(1, REG_Y, REG_A, 1);
    run_xfer(1, REG_M1, REG_M1, 1);
    run_xfer(1, REG_B, REG_C, 2);

    // Reset in the middle of LOAD: strobes drop at once, no done follows.
    @(negedge clk);
    src_idx = 4'(REG_A);
    dst_idx = 4'(REG_B);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_load", {24'd0, load_a}, 32'h02);
    #2 reset = 1'b1;
    #1;
    check("rst_sel", {24'd0, sel_a}, 32'd0);
    check("rst_load", {24'd0, load_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("no_done c%0d", c), {30'd0, busy_a, done_a}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
